// File: rtl/cpu_core.sv
// -----------------------------------------------------------------------------
// cpu_core -- small accumulator-style CPU with A, D and PC registers.
//
// Instruction word (16 bits):
//   inst[15] = 0 : A <= zero-extended inst[14:0], PC <= PC + 1
//   inst[15] = 1 : compute instruction
//       inst[12]   sm   : Y operand is *A (memory) when set, else A
//       inst[10:6] u, op1, op0, zx, sw
//       inst[5:3]  dst  : {a, d, *a}
//       inst[2:0]  j    : {lt, eq, gt}
//
// Sequencing: FETCH -> [MEM_RD] -> EXEC -> [MEM_WR] -> FETCH, plus an
// optional terminal HALT state.
//
// Optional feature: define CPU_CORE_HALT_EN to make a compute instruction
// with j = 111 that jumps to its own address enter HALT (halted = 1, no
// further requests until rst). Without the macro that instruction simply
// loops and halted is tied low.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   imem_req / imem_addr     instruction fetch request and address (= PC)
//   imem_ack / imem_data     fetch completion and instruction word
//   dmem_rd / dmem_wr        data read / write requests (mutually exclusive)
//   dmem_addr / dmem_wdata   data address (pre-instruction A) and write data
//   dmem_rdata / dmem_ack    read data and transaction completion
//   halted                   core stopped in HALT
//   pc                       current program counter (debug)
// -----------------------------------------------------------------------------
module cpu_core #(
    parameter int WIDTH  = 16,
    parameter int PC_W   = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WIDTH-1:0]  dmem_wdata,
    input  logic [WIDTH-1:0]  dmem_rdata,
    input  logic              dmem_ack,
    output logic              halted,
    output logic [PC_W-1:0]   pc
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_MEM_RD,
        S_EXEC,
        S_MEM_WR,
        S_HALT
    } state_t;

    state_t              state_reg;
    logic [PC_W-1:0]     pc_reg;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    d_reg;
    logic [WIDTH-1:0]    mem_a_reg;     // latched *A operand
    logic [15:0]         inst_reg;
    logic [WIDTH-1:0]    result_reg;    // ALU result held across MEM_WR
    logic                jump_reg;      // jump decision held across MEM_WR
    logic                halt_reg;      // halt decision held across MEM_WR
    logic                imem_req_reg;
    logic                dmem_rd_reg;
    logic                dmem_wr_reg;
    logic [ADDR_W-1:0]   dmem_addr_reg;

    // Decoded fields of the latched instruction
    logic       f_sm, f_u, f_zx, f_sw, f_dst_a, f_dst_d, f_dst_m;
    logic [1:0] f_op;
    logic [2:0] f_j;

    assign f_sm    = inst_reg[12];
    assign f_u     = inst_reg[10];
    assign f_op    = inst_reg[9:8];
    assign f_zx    = inst_reg[7];
    assign f_sw    = inst_reg[6];
    assign f_dst_a = inst_reg[5];
    assign f_dst_d = inst_reg[4];
    assign f_dst_m = inst_reg[3];
    assign f_j     = inst_reg[2:0];

    // ALU datapath
    logic [WIDTH-1:0] y_val, x_op, y_op, alu_result;
    logic             res_neg, res_zero, res_pos, take_jump, halt_hit;
    logic [PC_W-1:0]  pc_plus1;

    always_comb begin
        y_val = f_sm ? mem_a_reg : a_reg;
        x_op  = f_sw ? y_val : d_reg;
        y_op  = f_sw ? d_reg : y_val;
        if (f_zx) begin
            x_op = '0;
        end
        case ({f_u, f_op})
            3'b100:  alu_result = x_op + y_op;
            3'b101:  alu_result = x_op + WIDTH'(1);
            3'b110:  alu_result = x_op - y_op;
            3'b111:  alu_result = x_op - WIDTH'(1);
            3'b000:  alu_result = x_op & y_op;
            3'b001:  alu_result = x_op | y_op;
            3'b010:  alu_result = x_op ^ y_op;
            default: alu_result = ~x_op;
        endcase
    end

    // Result is interpreted as a signed WIDTH-bit value for the jump test.
    assign res_neg   = alu_result[WIDTH-1];
    assign res_zero  = (alu_result == '0);
    assign res_pos   = !res_neg && !res_zero;
    assign take_jump = (f_j[2] && res_neg) || (f_j[1] && res_zero) || (f_j[0] && res_pos);
    assign pc_plus1  = pc_reg + PC_W'(1);

`ifdef CPU_CORE_HALT_EN
    // j = 111 always jumps; jumping to its own address is the halt idiom.
    assign halt_hit = (f_j == 3'b111) && (a_reg[PC_W-1:0] == pc_reg);
    assign halted   = (state_reg == S_HALT);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // Commit point: EXEC of a compute instruction without a memory write,
    // or completion of the memory write. In MEM_WR the held copies are used.
    logic             commit_now, commit_jump, commit_halt;
    logic [WIDTH-1:0] commit_result;

    always_comb begin
        commit_now    = 1'b0;
        commit_result = alu_result;
        commit_jump   = take_jump;
        commit_halt   = halt_hit;
        if (state_reg == S_EXEC && inst_reg[15] && !f_dst_m) begin
            commit_now = 1'b1;
        end else if (state_reg == S_MEM_WR && dmem_ack) begin
            commit_now    = 1'b1;
            commit_result = result_reg;
            commit_jump   = jump_reg;
            commit_halt   = halt_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_FETCH;
            pc_reg        <= '0;
            a_reg         <= '0;
            d_reg         <= '0;
            mem_a_reg     <= '0;
            inst_reg      <= '0;
            result_reg    <= '0;
            jump_reg      <= 1'b0;
            halt_reg      <= 1'b0;
            imem_req_reg  <= 1'b0;
            dmem_rd_reg   <= 1'b0;
            dmem_wr_reg   <= 1'b0;
            dmem_addr_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    // The request is raised one cycle after reset release;
                    // acks seen while it is low are ignored.
                    if (imem_req_reg && imem_ack) begin
                        inst_reg     <= imem_data;
                        imem_req_reg <= 1'b0;
                        if (imem_data[15] && imem_data[12]) begin
                            state_reg     <= S_MEM_RD;
                            dmem_rd_reg   <= 1'b1;
                            dmem_addr_reg <= a_reg[ADDR_W-1:0];
                        end else begin
                            state_reg <= S_EXEC;
                        end
                    end else begin
                        imem_req_reg <= 1'b1;
                    end
                end
                S_MEM_RD: begin
                    if (dmem_ack) begin
                        mem_a_reg   <= dmem_rdata;
                        dmem_rd_reg <= 1'b0;
                        state_reg   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!inst_reg[15]) begin
                        a_reg        <= WIDTH'(inst_reg[14:0]);
                        pc_reg       <= pc_plus1;
                        state_reg    <= S_FETCH;
                        imem_req_reg <= 1'b1;
                    end else if (f_dst_m) begin
                        // Hold result and decisions; A/D/PC commit after the write.
                        result_reg    <= alu_result;
                        jump_reg      <= take_jump;
                        halt_reg      <= halt_hit;
                        dmem_addr_reg <= a_reg[ADDR_W-1:0];
                        dmem_wr_reg   <= 1'b1;
                        state_reg     <= S_MEM_WR;
                    end
                end
                S_MEM_WR: begin
                    if (dmem_ack) begin
                        dmem_wr_reg <= 1'b0;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase

            if (commit_now) begin
                if (f_dst_a) begin
                    a_reg <= commit_result;
                end
                if (f_dst_d) begin
                    d_reg <= commit_result;
                end
                // a_reg is still the pre-instruction A here.
                pc_reg <= commit_jump ? a_reg[PC_W-1:0] : pc_plus1;
                if (commit_halt) begin
                    state_reg <= S_HALT;
                end else begin
                    state_reg    <= S_FETCH;
                    imem_req_reg <= 1'b1;
                end
            end
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign dmem_rd    = dmem_rd_reg;
    assign dmem_wr    = dmem_wr_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_wdata = result_reg;

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        halted;
    logic [15:0] pc;

    cpu_core dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .halted     (halted),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entry: kind 0 = fetch, 1 = read, 2 = write.
    // data is the response (fetch/read) or the required write data.
    // dly < 0 means observe the request but never acknowledge it.
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          dly;
    } txn_t;

    txn_t sb[$];
    int   fetch_times[$];
    bit   stalled = 1'b0;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
        bit          rd;
        logic [15:0] rd_addr;
        logic [15:0] rd_data;
        bit          wr;
        logic [15:0] wr_addr;
        logic [15:0] wr_data;
    } vec_t;

    localparam int NVEC = 27;
    vec_t prog[NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ci(input bit sm, input bit u, input bit [1:0] op,
                                       input bit zx, input bit sw, input bit [2:0] dst,
                                       input bit [2:0] j);
        return {1'b1, 2'b00, sm, 1'b0, u, op, zx, sw, dst, j};
    endfunction

    function automatic vec_t mk(input logic [15:0] inst, input logic [15:0] p,
                                input bit rd, input logic [15:0] ra, input logic [15:0] rdat,
                                input bit wr, input logic [15:0] wa, input logic [15:0] wd);
        vec_t v;
        v.inst = inst; v.pc = p;
        v.rd = rd; v.rd_addr = ra; v.rd_data = rdat;
        v.wr = wr; v.wr_addr = wa; v.wr_data = wd;
        return v;
    endfunction

    task automatic push(input int kind, input logic [15:0] addr, input logic [15:0] data,
                        input int dly);
        txn_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.dly = dly;
        sb.push_back(e);
    endtask

    // Memory-side responder: pops the expected transaction when a request
    // appears, checks it, holds for the delay (with stray acks of the other
    // port) and then acknowledges.
    initial begin : responder
        txn_t        e;
        int          kind;
        logic [15:0] a0;
        logic [15:0] w0;
        bit          stable;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_data = '0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (rst) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled || sb.size() == 0) continue;
            if (!(imem_req === 1'b1 || dmem_rd === 1'b1 || dmem_wr === 1'b1)) continue;
            e    = sb.pop_front();
            kind = imem_req ? 0 : (dmem_rd ? 1 : 2);
            a0   = imem_req ? imem_addr : dmem_addr;
            w0   = dmem_wdata;
            chk("req_exclusive", 64'($countones({imem_req, dmem_rd, dmem_wr})), 64'd1);
            chk("txn_kind", 64'(kind), 64'(e.kind));
            chk("txn_addr", 64'(a0), 64'(e.addr));
            if (e.kind == 2) chk("wdata", 64'(w0), 64'(e.data));
            $display("txn cyc=%0d kind=%0d addr=%h data=%h dly=%0d", cyc, kind, a0,
                     (kind == 2) ? w0 : e.data, e.dly);
            if (kind == 0) fetch_times.push_back(cyc);
            if (e.dly < 0) begin
                stalled = 1'b1;
                continue;
            end
            stable = 1'b1;
            for (int k = 0; k < e.dly; k++) begin
                // Stray ack on the port that has no request pending.
                if (kind == 0) begin
                    dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
                end else begin
                    imem_ack = 1'b1; imem_data = 16'hFFFF;
                end
                @(negedge clk);
                imem_ack = 1'b0;
                dmem_ack = 1'b0;
                if (kind == 0 && (!imem_req || imem_addr != a0 || dmem_rd || dmem_wr)) stable = 1'b0;
                if (kind == 1 && (!dmem_rd || dmem_addr != a0 || imem_req || dmem_wr)) stable = 1'b0;
                if (kind == 2 && (!dmem_wr || dmem_addr != a0 || dmem_wdata != w0 ||
                                  imem_req || dmem_rd)) stable = 1'b0;
            end
            if (e.dly > 0) chk("req_stable", 64'(stable), 64'd1);
            if (kind == 0) begin
                imem_data = e.data;
                imem_ack  = 1'b1;
            end else begin
                if (kind == 1) dmem_rdata = e.data;
                dmem_ack = 1'b1;
            end
        end
    end

    task automatic do_reset(input string name);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_imem_req"}, 64'(imem_req), 64'd0);
        chk({name, "_dmem_rd"},  64'(dmem_rd),  64'd0);
        chk({name, "_dmem_wr"},  64'(dmem_wr),  64'd0);
        chk({name, "_pc"},       64'(pc),       64'd0);
        chk({name, "_halted"},   64'(halted),   64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        fetch_times.delete();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        // dst codes: a=100, d=010, *a=001; j codes: lt=100, eq=010, gt=001
        prog[0]  = mk(16'h1234,                            16'd0,  0, 0, 0, 0, 0, 0);
        prog[1]  = mk(ci(0,1,2'd0,1,0,3'b001,3'b000),      16'd1,  0, 0, 0, 1, 16'h1234, 16'h1234);
        prog[2]  = mk(ci(0,1,2'd0,1,1,3'b001,3'b000),      16'd2,  0, 0, 0, 1, 16'h1234, 16'h0000);
        prog[3]  = mk(16'h0003,                            16'd3,  0, 0, 0, 0, 0, 0);
        prog[4]  = mk(ci(0,1,2'd0,1,0,3'b010,3'b000),      16'd4,  0, 0, 0, 0, 0, 0);
        prog[5]  = mk(16'h0005,                            16'd5,  0, 0, 0, 0, 0, 0);
        prog[6]  = mk(ci(0,1,2'd2,0,0,3'b010,3'b000),      16'd6,  0, 0, 0, 0, 0, 0);
        prog[7]  = mk(ci(0,1,2'd0,1,1,3'b001,3'b000),      16'd7,  0, 0, 0, 1, 16'h0005, 16'hFFFE);
        prog[8]  = mk(ci(0,0,2'd1,0,0,3'b001,3'b000),      16'd8,  0, 0, 0, 1, 16'h0005, 16'hFFFF);
        prog[9]  = mk(ci(0,0,2'd2,0,0,3'b001,3'b000),      16'd9,  0, 0, 0, 1, 16'h0005, 16'hFFFB);
        prog[10] = mk(ci(0,0,2'd3,0,0,3'b001,3'b000),      16'd10, 0, 0, 0, 1, 16'h0005, 16'h0001);
        prog[11] = mk(ci(0,0,2'd0,0,0,3'b001,3'b000),      16'd11, 0, 0, 0, 1, 16'h0005, 16'h0004);
        prog[12] = mk(ci(0,1,2'd3,0,0,3'b001,3'b000),      16'd12, 0, 0, 0, 1, 16'h0005, 16'hFFFD);
        prog[13] = mk(ci(0,1,2'd1,0,0,3'b001,3'b000),      16'd13, 0, 0, 0, 1, 16'h0005, 16'hFFFF);
        prog[14] = mk(ci(0,1,2'd2,0,1,3'b001,3'b000),      16'd14, 0, 0, 0, 1, 16'h0005, 16'h0007);
        prog[15] = mk(ci(1,1,2'd0,0,0,3'b001,3'b000),      16'd15, 1, 16'h0005, 16'h0100, 1, 16'h0005, 16'h00FE);
        prog[16] = mk(ci(1,1,2'd0,0,0,3'b111,3'b000),      16'd16, 1, 16'h0005, 16'h0002, 1, 16'h0005, 16'h0000);
        prog[17] = mk(ci(0,1,2'd1,0,0,3'b001,3'b000),      16'd17, 0, 0, 0, 1, 16'h0000, 16'h0001);
        prog[18] = mk(16'h0030,                            16'd18, 0, 0, 0, 0, 0, 0);
        prog[19] = mk(ci(0,1,2'd0,1,1,3'b000,3'b010),      16'd19, 0, 0, 0, 0, 0, 0);
        prog[20] = mk(ci(0,1,2'd3,0,0,3'b010,3'b100),      16'h30, 0, 0, 0, 0, 0, 0);
        prog[21] = mk(ci(0,1,2'd0,1,1,3'b000,3'b010),      16'h30, 0, 0, 0, 0, 0, 0);
        prog[22] = mk(ci(0,1,2'd0,1,1,3'b000,3'b001),      16'h31, 0, 0, 0, 0, 0, 0);
        prog[23] = mk(ci(0,1,2'd1,0,0,3'b010,3'b010),      16'h32, 0, 0, 0, 0, 0, 0);
        prog[24] = mk(ci(0,1,2'd0,1,0,3'b000,3'b001),      16'h30, 0, 0, 0, 0, 0, 0);
        prog[25] = mk(16'h0007,                            16'h30, 0, 0, 0, 0, 0, 0);
        prog[26] = mk(ci(0,1,2'd0,1,0,3'b001,3'b000),      16'h31, 0, 0, 0, 1, 16'h0007, 16'h0007);

        // ---- Table-driven program with varied wait states ----
        do_reset("reset0");
        for (int i = 0; i < NVEC; i++) begin
            push(0, prog[i].pc, prog[i].inst, i % 3);
            if (prog[i].rd) push(1, prog[i].rd_addr, prog[i].rd_data, (i % 2) + 1);
            if (prog[i].wr) push(2, prog[i].wr_addr, prog[i].wr_data, i % 4);
        end
        push(0, 16'h0032, 16'h0000, -1);
        wait_done(3000, "table");
        chk("table_halted", 64'(halted), 64'd0);

        // ---- Zero-wait latency: 2 cycles plain, 10 with 3-cycle read and write ----
        do_reset("reset1");
        push(0, 16'd0, ci(0,1,2'd1,1,0,3'b010,3'b000), 0);   // D = 1
        push(0, 16'd1, 16'h0040, 0);                          // A = 0x40
        push(0, 16'd2, ci(1,1,2'd0,0,0,3'b001,3'b000), 0);   // *A = *A + D
        push(1, 16'h0040, 16'h0011, 3);
        push(2, 16'h0040, 16'h0012, 3);
        push(0, 16'd3, 16'h0000, -1);
        wait_done(500, "latency");
        chk("latency_nfetch", 64'(fetch_times.size()), 64'd4);
        if (fetch_times.size() == 4) begin
            chk("latency_const", 64'(fetch_times[1] - fetch_times[0]), 64'd2);
            chk("latency_alu",   64'(fetch_times[2] - fetch_times[1]), 64'd2);
            chk("latency_rdwr",  64'(fetch_times[3] - fetch_times[2]), 64'd10);
        end

        // ---- Reset while a write is pending ----
        do_reset("reset2");
        push(0, 16'd0, 16'h0040, 0);                          // A = 0x40
        push(0, 16'd1, ci(0,1,2'd1,0,1,3'b101,3'b000), 0);   // A,*A = A + 1
        push(2, 16'h0040, 16'h0041, -1);
        wait_done(500, "midwr");
        repeat (3) @(negedge clk);
        chk("midwr_held", 64'(dmem_wr), 64'd1);
        do_reset("reset_midwr");
        // A must be back to 0: *A = A writes 0 to address 0.
        push(0, 16'd0, ci(0,1,2'd0,1,0,3'b001,3'b000), 0);
        push(2, 16'h0000, 16'h0000, 1);
        push(0, 16'd1, 16'h0000, -1);
        wait_done(500, "after_rst");

        // ---- Self-jump with j = 111 ----
        do_reset("reset3");
        push(0, 16'd0, 16'h0001, 0);                          // A = 1
        push(0, 16'd1, ci(0,0,2'd0,1,0,3'b000,3'b111), 0);   // 0;JMP to 1
`ifdef CPU_CORE_HALT_EN
        wait_done(500, "halt");
        repeat (8) @(negedge clk);
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_no_req", 64'(imem_req), 64'd0);
        chk("halt_nfetch", 64'(fetch_times.size()), 64'd2);
`else
        push(0, 16'd1, 16'h0000, -1);
        wait_done(500, "loop");
        chk("loop_halted", 64'(halted), 64'd0);
        chk("loop_nfetch", 64'(fetch_times.size()), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
